pipeline_stall_controller: RTL and testbench

Sequences the 5-stage MIPS pipeline's register enables from the hazard detection output, branch/jump resolution in ID and HALT detection. Produces PC/IF-ID write enables, the IF-ID flush and the ID-EX bubble. Runs a small FSM (idle, run, multi-cycle stall, halt drain, halted) gated by the debug unit's step enable. Keeps cycle and stall counters for the debug unit to read out.

---
 rtl/pipeline_stall_controller_pkg.sv | 32 +++
 rtl/pipeline_stall_controller_stall_down_counter.sv | 44 ++++
 rtl/pipeline_stall_controller.sv | 159 +++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller_pkg
// Description : State encodings and default countdown lengths shared by the
//               pipeline stall controller and its down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_stall_controller_pkg;

    localparam int          c_NB_STATE = 3;

    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_RUN    = 3'd1;
    localparam logic [2:0]  c_ST_STALL  = 3'd2;
    localparam logic [2:0]  c_ST_DRAIN  = 3'd3;
    localparam logic [2:0]  c_ST_HALTED = 3'd4;

    typedef enum logic [c_NB_STATE-1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_RUN    = c_ST_RUN,
        ST_STALL  = c_ST_STALL,
        ST_DRAIN  = c_ST_DRAIN,
        ST_HALTED = c_ST_HALTED
    } state_t;

    // Branch on a load result waits until the load leaves MEM.
    localparam int c_DEFAULT_BRANCH_STALL_CYCLES = 2;
    // HALT in ID waits until the instruction ahead of it retires in WB.
    localparam int c_DEFAULT_DRAIN_CYCLES        = 3;

endpackage : pipeline_stall_controller_pkg
`default_nettype wire

// File: rtl/pipeline_stall_controller_stall_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller_stall_down_counter
// Description : Loadable down-counter with a "reads one" flag, used to time
//               both the multi-cycle branch stall and the HALT drain.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller_stall_down_counter #(
    parameter int NB_STALL = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [NB_STALL-1:0] i_load_value,
    input  logic                i_dec,
    output logic                o_is_one
);

    logic [NB_STALL-1:0] count_q;
    logic [NB_STALL-1:0] count_d;

    // Load has priority over decrement; otherwise hold.
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_value;
        end else if (i_dec) begin
            count_d = count_q - NB_STALL'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_is_one = (count_q == NB_STALL'(1));

endmodule : pipeline_stall_controller_stall_down_counter
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Drives PC / IF-ID write enables, IF-ID flush and ID-EX bubble
//               of the 5-stage pipeline from hazard, branch and HALT inputs,
//               gated by the debug-unit advance enable. Keeps cycle and stall
//               counters for debug readout.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int NB_COUNT            = 32,
    parameter int NB_STALL            = 2,
    parameter int BRANCH_STALL_CYCLES = c_DEFAULT_BRANCH_STALL_CYCLES,
    parameter int DRAIN_CYCLES        = c_DEFAULT_DRAIN_CYCLES
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_start,
    input  logic                i_load_use,
    input  logic                i_branch_load,
    input  logic                i_branch_taken,
    input  logic                i_halt,
    output logic                o_pc_we,
    output logic                o_if_id_we,
    output logic                o_if_id_flush,
    output logic                o_id_ex_bubble,
    output logic                o_halted,
    output logic [NB_COUNT-1:0] o_cycle_count,
    output logic [NB_COUNT-1:0] o_stall_count
);

    // Countdown load values: number of extra cycles after the triggering one.
    localparam logic [NB_STALL-1:0] c_BRANCH_LOAD = NB_STALL'(BRANCH_STALL_CYCLES - 1);
    localparam logic [NB_STALL-1:0] c_DRAIN_LOAD  = NB_STALL'(DRAIN_CYCLES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [NB_COUNT-1:0] cycle_count_q;
    logic [NB_COUNT-1:0] cycle_count_d;
    logic [NB_COUNT-1:0] stall_count_q;
    logic [NB_COUNT-1:0] stall_count_d;

    logic                w_cnt_load;
    logic [NB_STALL-1:0] w_cnt_value;
    logic                w_cnt_dec;
    logic                w_cnt_is_one;
    logic                w_clear;

    pipeline_stall_controller_stall_down_counter #(
        .NB_STALL (NB_STALL)
    ) u_down_counter (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_load       (w_cnt_load),
        .i_load_value (w_cnt_value),
        .i_dec        (w_cnt_dec),
        .o_is_one     (w_cnt_is_one)
    );

    // Next state and same-cycle pipeline controls; nothing moves without i_valid.
    always_comb begin
        state_d        = state_q;
        o_pc_we        = 1'b0;
        o_if_id_we     = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_value    = '0;
        w_cnt_dec      = 1'b0;
        w_clear        = 1'b0;
        if (i_valid) begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (i_start) begin
                        state_d = ST_RUN;
                        w_clear = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_halt) begin
                        // HALT itself travels on as a NOP, so no bubble here.
                        w_cnt_load  = 1'b1;
                        w_cnt_value = c_DRAIN_LOAD;
                        state_d     = (c_DRAIN_LOAD != '0) ? ST_DRAIN : ST_HALTED;
                    end else if (i_branch_load) begin
                        // A stall hides any same-cycle taken branch; it is
                        // re-evaluated once its operands are ready.
                        o_id_ex_bubble = 1'b1;
                        w_cnt_load     = 1'b1;
                        w_cnt_value    = c_BRANCH_LOAD;
                        state_d        = (c_BRANCH_LOAD != '0) ? ST_STALL : ST_RUN;
                    end else if (i_load_use) begin
                        o_id_ex_bubble = 1'b1;
                    end else begin
                        o_pc_we       = 1'b1;
                        o_if_id_we    = 1'b1;
                        o_if_id_flush = i_branch_taken;
                    end
                end
                ST_STALL: begin
                    o_id_ex_bubble = 1'b1;
                    w_cnt_dec      = 1'b1;
                    if (w_cnt_is_one) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    o_id_ex_bubble = 1'b1;
                    w_cnt_dec      = 1'b1;
                    if (w_cnt_is_one) begin
                        state_d = ST_HALTED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Performance counters: clear on start, otherwise count advanced cycles.
    always_comb begin
        cycle_count_d = cycle_count_q;
        stall_count_d = stall_count_q;
        if (w_clear) begin
            cycle_count_d = '0;
            stall_count_d = '0;
        end else if (i_valid) begin
            if (state_q == ST_RUN || state_q == ST_STALL || state_q == ST_DRAIN) begin
                cycle_count_d = cycle_count_q + NB_COUNT'(1);
            end
            if (!o_pc_we && (state_q == ST_RUN || state_q == ST_STALL)) begin
                stall_count_d = stall_count_q + NB_COUNT'(1);
            end
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q       <= ST_IDLE;
            cycle_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_halted      = (state_q == ST_HALTED);
    assign o_cycle_count = cycle_count_q;
    assign o_stall_count = stall_count_q;

endmodule : pipeline_stall_controller
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Scoreboard bench for pipeline_stall_controller: directed
//               scenarios followed by random stimulus, checked against a
//               mode/remaining-cycles reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    localparam int NB_COUNT = 32;
    localparam int BSC      = 2;
    localparam int DC       = 3;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STALL  = 2;
    localparam int M_DRAIN  = 3;
    localparam int M_HALTED = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                valid, start, load_use, branch_load, branch_taken, halt;
    logic                pc_we, if_id_we, if_id_flush, id_ex_bubble, halted;
    logic [NB_COUNT-1:0] cycle_count, stall_count;

    typedef struct packed {
        logic [4:0]          ctl;   // {pc_we, if_id_we, flush, bubble, halted}
        logic [NB_COUNT-1:0] cyc;
        logic [NB_COUNT-1:0] stl;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: operating mode plus number of forced cycles left.
    int                  m_mode;
    int                  m_left;
    logic [NB_COUNT-1:0] m_cyc;
    logic [NB_COUNT-1:0] m_stl;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .NB_COUNT            (NB_COUNT),
        .NB_STALL            (2),
        .BRANCH_STALL_CYCLES (BSC),
        .DRAIN_CYCLES        (DC)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_valid        (valid),
        .i_start        (start),
        .i_load_use     (load_use),
        .i_branch_load  (branch_load),
        .i_branch_taken (branch_taken),
        .i_halt         (halt),
        .o_pc_we        (pc_we),
        .o_if_id_we     (if_id_we),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_bubble (id_ex_bubble),
        .o_halted       (halted),
        .o_cycle_count  (cycle_count),
        .o_stall_count  (stall_count)
    );

    // One cycle of stimulus: drive, push expected response, advance model.
    task automatic step(input logic rn, input logic v, input logic s, input logic lu,
                        input logic bl, input logic bt, input logic h);
        exp_t e;
        logic pc, ifid, fl, bub;
        @(posedge clk);
        #1;
        rst_n = rn; valid = v; start = s; load_use = lu;
        branch_load = bl; branch_taken = bt; halt = h;

        pc = 1'b0; ifid = 1'b0; fl = 1'b0; bub = 1'b0;
        if (v) begin
            if (m_mode == M_RUN) begin
                if (h) begin
                    bub = 1'b0;
                end else if (bl || lu) begin
                    bub = 1'b1;
                end else begin
                    pc = 1'b1; ifid = 1'b1; fl = bt;
                end
            end else if (m_mode == M_STALL || m_mode == M_DRAIN) begin
                bub = 1'b1;
            end
        end
        e.ctl = {pc, ifid, fl, bub, (m_mode == M_HALTED)};
        e.cyc = m_cyc;
        e.stl = m_stl;
        q.push_back(e);

        if (!rn) begin
            m_mode = M_IDLE; m_left = 0; m_cyc = '0; m_stl = '0;
        end else if (v) begin
            if (m_mode == M_RUN || m_mode == M_STALL || m_mode == M_DRAIN)
                m_cyc = m_cyc + 1;
            if (!pc && (m_mode == M_RUN || m_mode == M_STALL))
                m_stl = m_stl + 1;
            case (m_mode)
                M_IDLE, M_HALTED: if (s) begin
                    m_mode = M_RUN; m_cyc = '0; m_stl = '0;
                end
                M_RUN: begin
                    if (h) begin
                        m_left = DC - 1;
                        m_mode = (m_left > 0) ? M_DRAIN : M_HALTED;
                    end else if (bl) begin
                        m_left = BSC - 1;
                        m_mode = (m_left > 0) ? M_STALL : M_RUN;
                    end
                end
                M_STALL: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_RUN;
                end
                M_DRAIN: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_HALTED;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [4:0] got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, halted};
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL ctl @%0t: got %b want %b (pc,ifid,flush,bubble,halted)",
                         $time, got, e.ctl);
            end
            checks++;
            if (cycle_count !== e.cyc) begin
                errors++;
                $display("FAIL cycle_count @%0t: got %0d want %0d", $time, cycle_count, e.cyc);
            end
            checks++;
            if (stall_count !== e.stl) begin
                errors++;
                $display("FAIL stall_count @%0t: got %0d want %0d", $time, stall_count, e.stl);
            end
        end
    end

    initial begin
        rst_n = 1'b0; valid = 1'b0; start = 1'b0; load_use = 1'b0;
        branch_load = 1'b0; branch_taken = 1'b0; halt = 1'b0;
        m_mode = M_IDLE; m_left = 0; m_cyc = '0; m_stl = '0;
        repeat (2) @(posedge clk);

        //    rn v  s  lu bl bt h
        step(1, 1, 0, 0, 0, 0, 0);      // idle after reset
        step(1, 1, 1, 0, 0, 0, 0);      // start
        repeat (3) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0);      // load-use
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 1, 0);      // branch-load with taken: no flush
        step(1, 1, 0, 0, 0, 1, 0);      // stall cycle ignores branch
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1, 0);      // lone taken branch -> flush
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1);      // halt
        step(1, 1, 1, 0, 0, 0, 1);      // drain ignores start/halt
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (2) step(1, 1, 0, 0, 0, 0, 0);   // halted, counters frozen
        step(1, 1, 1, 0, 0, 0, 0);      // restart
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 0);      // branch-load
        repeat (3) step(1, 0, 1, 1, 1, 1, 1);   // frozen mid-stall
        step(1, 1, 0, 0, 0, 0, 0);      // stall completes
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1);      // halt
        step(1, 1, 0, 0, 0, 0, 0);      // drain
        step(0, 1, 0, 0, 0, 0, 0);      // reset during drain
        step(1, 1, 0, 0, 0, 0, 0);      // idle after reset
        step(1, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 3));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipeline_stall_controller
`default_nettype wire
